// File: rtl/cache_mem_responder_pkg.sv
// Shared types and helpers for the cache main-memory responder: state encoding,
// default geometry and the deterministic fill pattern for lines never written back.
package cache_mem_responder_pkg;

  localparam int DEF_ADDR_SIZE      = 32;
  localparam int DEF_DATA_SIZE      = 32;
  localparam int DEF_BLOCK_SIZE     = 6;
  localparam int DEF_MEM_LINES_LOG2 = 8;
  localparam int DEF_BLOCKS         = 2 ** DEF_BLOCK_SIZE;
  localparam int LAT_W              = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_WAIT   = 3'd1,
    LD_RESP   = 3'd2,
    WB_WAIT   = 3'd3,
    WB_ACCEPT = 3'd4
  } mem_state_t;

  function automatic int blocks_of(input int block_size);
    return 2 ** block_size;
  endfunction

  // Word j of unwritten line L reads as {L[15:0], j[15:0]} ^ seed.
  function automatic logic [31:0] fill_pattern(input logic [31:0] line,
                                               input logic [31:0] word,
                                               input logic [31:0] seed);
    return {line[15:0], word[15:0]} ^ seed;
  endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Memory-side bus between cache_top (master) and the memory responder (slave).
interface cache_mem_responder_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_SIZE  = 32,
  parameter int BLOCK_SIZE = 6
);
  localparam int BLOCKS = 2 ** BLOCK_SIZE;

  // Handshakes: addr_valid_out is held by the cache until serviced; a fill
  // transfers on the edge where valid_ld && ready_ld, a writeback on the edge
  // where valid_wb && ready_wb. Once raised, valid_ld/data_in_m and ready_wb
  // stay stable until their transfer edge.
  logic                           addr_valid_out;
  logic [ADDR_SIZE-1:0]           addr_out_m;
  logic                           rw_out;
  logic                           valid_ld;
  logic [BLOCKS*DATA_SIZE-1:0]    data_in_m;
  logic                           ready_ld;
  logic                           valid_wb;
  logic [BLOCKS*DATA_SIZE-1:0]    data_out_m;
  logic                           ready_wb;

  modport master (
    output addr_valid_out, addr_out_m, rw_out, ready_ld, valid_wb, data_out_m,
    input  valid_ld, data_in_m, ready_wb
  );

  modport slave (
    input  addr_valid_out, addr_out_m, rw_out, ready_ld, valid_wb, data_out_m,
    output valid_ld, data_in_m, ready_wb
  );

endinterface

// File: rtl/cache_mem_responder_line_store.sv
// Line-granular backing store: one write port, one combinational read port, plus
// per-line written bits that are cleared by reset while the data array is not.
module cache_mem_responder_line_store #(
  parameter int LINES_LOG2 = 8,
  parameter int LINE_W     = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [LINES_LOG2-1:0] waddr_i,
  input  logic [LINE_W-1:0]     wdata_i,
  input  logic [LINES_LOG2-1:0] raddr_i,
  output logic [LINE_W-1:0]     rdata_o,
  output logic                  rwritten_o
);
  localparam int LINES = 2 ** LINES_LOG2;

  logic [LINE_W-1:0] mem_q [LINES];
  logic [LINES-1:0]  written_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    written_q          <= '0;
    else if (we_i) written_q[waddr_i] <= 1'b1;
  end

  assign rdata_o    = mem_q[raddr_i];
  assign rwritten_o = written_q[raddr_i];

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory responder for the cache's memory side: serves line fills and dirty
// writebacks with fixed latencies, one request at a time, with transfer counters.
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int          ADDR_SIZE      = 32,
  parameter int          DATA_SIZE      = 32,
  parameter int          BLOCK_SIZE     = 6,
  parameter int          MEM_LINES_LOG2 = 8,
  parameter int          LD_LATENCY     = 4,
  parameter int          WB_LATENCY     = 2,
  parameter logic [31:0] PATTERN_SEED   = 32'hA5A5_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cache_mem_responder_if.slave    mem,
  output logic                    busy,
  output logic [15:0]             ld_count,
  output logic [15:0]             wb_count,
  output logic                    protocol_err,
  output mem_state_t              dbg_state_o
);
  localparam int BLOCKS = blocks_of(BLOCK_SIZE);
  localparam int LINE_W = BLOCKS * DATA_SIZE;

  mem_state_t                state_q, state_d;
  logic [LAT_W-1:0]          cnt_q, cnt_d;
  logic [MEM_LINES_LOG2-1:0] line_q, line_d;
  logic [ADDR_SIZE-1:0]      addr_q, addr_d;
  logic                      rw_q, rw_d;
  logic                      valid_ld_q, valid_ld_d;
  logic [LINE_W-1:0]         data_q, data_d;
  logic                      ready_wb_q, ready_wb_d;
  logic [15:0]               ld_count_q, ld_count_d;
  logic [15:0]               wb_count_q, wb_count_d;
  logic                      perr_q, perr_d;

  logic                      store_we;
  logic [LINE_W-1:0]         store_rdata;
  logic                      store_written;
  logic [LINE_W-1:0]         pattern_line;
  logic [LINE_W-1:0]         fill_line;

  cache_mem_responder_line_store #(
    .LINES_LOG2 (MEM_LINES_LOG2),
    .LINE_W     (LINE_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (store_we),
    .waddr_i    (line_q),
    .wdata_i    (mem.data_out_m),
    .raddr_i    (line_q),
    .rdata_o    (store_rdata),
    .rwritten_o (store_written)
  );

  always_comb begin
    pattern_line = '0;
    for (int j = 0; j < BLOCKS; j++) begin
      pattern_line[j*DATA_SIZE +: DATA_SIZE] =
        DATA_SIZE'(fill_pattern(32'(line_q), 32'(j), PATTERN_SEED));
    end
    fill_line = store_written ? store_rdata : pattern_line;
  end

  assign store_we = (state_q == WB_ACCEPT) && mem.valid_wb && ready_wb_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    valid_ld_d = valid_ld_q;
    data_d     = data_q;
    ready_wb_d = ready_wb_q;
    ld_count_d = ld_count_q;
    wb_count_d = wb_count_q;
    perr_d     = perr_q;

    unique case (state_q)
      IDLE: begin
        if (mem.addr_valid_out) begin
          line_d  = mem.addr_out_m[BLOCK_SIZE +: MEM_LINES_LOG2];
          addr_d  = mem.addr_out_m;
          rw_d    = mem.rw_out;
          cnt_d   = mem.rw_out ? LAT_W'(WB_LATENCY - 1) : LAT_W'(LD_LATENCY - 1);
          state_d = mem.rw_out ? WB_WAIT : LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = LD_RESP;
          valid_ld_d = 1'b1;
          data_d     = fill_line;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LD_RESP: begin
        if (valid_ld_q && mem.ready_ld) begin
          valid_ld_d = 1'b0;
          ld_count_d = (ld_count_q == 16'hFFFF) ? ld_count_q : ld_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      WB_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = WB_ACCEPT;
          ready_wb_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WB_ACCEPT: begin
        if (store_we) begin
          ready_wb_d = 1'b0;
          wb_count_d = (wb_count_q == 16'hFFFF) ? wb_count_q : wb_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A held request must not change under us while its latency runs.
    if (mem.valid_wb && (state_q != WB_ACCEPT)) perr_d = 1'b1;
    if (((state_q == LD_WAIT) || (state_q == WB_WAIT)) && mem.addr_valid_out &&
        ((mem.rw_out != rw_q) || (mem.addr_out_m != addr_q))) perr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      valid_ld_q <= 1'b0;
      data_q     <= '0;
      ready_wb_q <= 1'b0;
      ld_count_q <= '0;
      wb_count_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      valid_ld_q <= valid_ld_d;
      data_q     <= data_d;
      ready_wb_q <= ready_wb_d;
      ld_count_q <= ld_count_d;
      wb_count_q <= wb_count_d;
      perr_q     <= perr_d;
    end
  end

  assign mem.valid_ld  = valid_ld_q;
  assign mem.data_in_m = data_q;
  assign mem.ready_wb  = ready_wb_q;
  assign busy          = (state_q != IDLE);
  assign ld_count      = ld_count_q;
  assign wb_count      = wb_count_q;
  assign protocol_err  = perr_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: table of load/writeback vectors with hand-computed
// words, plus directed sequences for stall, protocol errors and mid-transaction reset.
module tb_cache_mem_responder;
  import cache_mem_responder_pkg::*;

  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          BS     = 6;
  localparam int          LL     = 8;
  localparam int          LDL    = 4;
  localparam int          WBL    = 2;
  localparam logic [31:0] SEED   = 32'hA5A5_0000;
  localparam int          BLOCKS = 64;
  localparam int          LW     = BLOCKS * DW;
  localparam int          NVEC   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_mem_responder_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .BLOCK_SIZE(BS)) mif ();

  logic        busy;
  logic [15:0] ld_count;
  logic [15:0] wb_count;
  logic        protocol_err;
  mem_state_t  dbg_state;

  cache_mem_responder #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .BLOCK_SIZE(BS), .MEM_LINES_LOG2(LL),
    .LD_LATENCY(LDL), .WB_LATENCY(WBL), .PATTERN_SEED(SEED)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem          (mif),
    .busy         (busy),
    .ld_count     (ld_count),
    .wb_count     (wb_count),
    .protocol_err (protocol_err),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int              n_cmp = 0;
  int              n_err = 0;
  logic [DW-1:0]   exp_q[$];
  logic [LW-1:0]   mdl_line [256];
  bit              mdl_wr   [256];
  int              exp_ld = 0;
  int              exp_wb = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] line_of(input logic [31:0] a);
    return a[BS +: LL];
  endfunction

  task automatic push_expected(input logic [7:0] l);
    for (int j = 0; j < BLOCKS; j++) begin
      if (mdl_wr[l]) exp_q.push_back(mdl_line[l][j*DW +: DW]);
      else           exp_q.push_back({8'h00, l, 16'(j)} ^ SEED);
    end
  endtask

  task automatic check_line(input string name, input logic [LW-1:0] got);
    logic [DW-1:0] e;
    bit bad;
    bad = 0;
    n_cmp++;
    for (int j = 0; j < BLOCKS; j++) begin
      e = exp_q.pop_front();
      if (!bad && got[j*DW +: DW] !== e) begin
        bad = 1;
        $display("FAIL %s word %0d: got %0h expected %0h", name, j, got[j*DW +: DW], e);
      end
    end
    if (bad) n_err++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n              = 1'b0;
    mif.addr_valid_out = 1'b0;
    mif.addr_out_m     = '0;
    mif.rw_out         = 1'b0;
    mif.ready_ld       = 1'b0;
    mif.valid_wb       = 1'b0;
    mif.data_out_m     = '0;
    for (int i = 0; i < 256; i++) mdl_wr[i] = 0;
    exp_ld = 0;
    exp_wb = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for a DUT output after the capture edge; returns edges counted from capture.
  task automatic wait_for(input bit is_ld, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(is_ld ? mif.valid_ld : mif.ready_wb) && lat < 50);
    lat = lat - 1;
  endtask

  task automatic do_load(input string name, input logic [31:0] addr, output logic [LW-1:0] got);
    int lat;
    @(negedge clk);
    mif.addr_out_m     = addr;
    mif.rw_out         = 1'b0;
    mif.addr_valid_out = 1'b1;
    wait_for(1'b1, lat);
    check({name, "_ld_latency"}, 64'(lat), 64'(LDL));
    check({name, "_busy_resp"}, 64'(busy), 64'd1);
    got = mif.data_in_m;
    push_expected(line_of(addr));
    check_line({name, "_line"}, got);
    mif.addr_valid_out = 1'b0;
    mif.ready_ld       = 1'b1;
    @(posedge clk); #1;
    mif.ready_ld = 1'b0;
    if (mif.valid_ld === 1'b0 || lat >= 50) exp_ld++;
    check({name, "_valid_ld_drop"}, 64'(mif.valid_ld), 64'd0);
    check({name, "_ld_count"}, 64'(ld_count), 64'(exp_ld));
  endtask

  task automatic do_wb(input string name, input logic [31:0] addr, input logic [31:0] word);
    int lat;
    @(negedge clk);
    mif.addr_out_m     = addr;
    mif.rw_out         = 1'b1;
    mif.addr_valid_out = 1'b1;
    wait_for(1'b0, lat);
    check({name, "_wb_latency"}, 64'(lat), 64'(WBL));
    mif.addr_valid_out = 1'b0;
    mif.valid_wb       = 1'b1;
    mif.data_out_m     = {BLOCKS{word}};
    @(posedge clk); #1;
    mif.valid_wb = 1'b0;
    mif.rw_out   = 1'b0;
    exp_wb++;
    mdl_line[line_of(addr)] = {BLOCKS{word}};
    mdl_wr[line_of(addr)]   = 1;
    check({name, "_ready_wb_drop"}, 64'(mif.ready_wb), 64'd0);
    check({name, "_wb_count"}, 64'(wb_count), 64'(exp_wb));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_w0;
    logic [31:0] exp_w63;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    logic [LW-1:0] got;
    logic [LW-1:0] held;
    int            lat;
    bit            unstable;

    vecs[0] = '{1'b0, 32'h0000_1234, 32'h0,         32'hA5ED_0000, 32'hA5ED_003F};
    vecs[1] = '{1'b1, 32'h0000_1200, 32'hDEAD_BEEF, 32'h0,         32'h0};
    vecs[2] = '{1'b0, 32'h0000_1200, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h0004_1234, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0000, 32'hA5A5_003F};
    vecs[5] = '{1'b1, 32'h0000_3FC0, 32'h1234_5678, 32'h0,         32'h0};
    vecs[6] = '{1'b0, 32'h0004_3FFF, 32'h0,         32'h1234_5678, 32'h1234_5678};
    vecs[7] = '{1'b0, 32'h0000_3F80, 32'h0,         32'hA55B_0000, 32'hA55B_003F};

    apply_reset();
    #1;
    check("rst_valid_ld", 64'(mif.valid_ld), 64'd0);
    check("rst_ready_wb", 64'(mif.ready_wb), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_perr", 64'(protocol_err), 64'd0);
    check("rst_ld_count", 64'(ld_count), 64'd0);
    check("rst_wb_count", 64'(wb_count), 64'd0);
    check("rst_data_in_m", 64'(mif.data_in_m == '0), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].rw) begin
        do_wb($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata);
      end else begin
        do_load($sformatf("vec%0d", i), vecs[i].addr, got);
        check($sformatf("vec%0d_word0", i), 64'(got[0 +: DW]), 64'(vecs[i].exp_w0));
        check($sformatf("vec%0d_word63", i), 64'(got[63*DW +: DW]), 64'(vecs[i].exp_w63));
      end
      check($sformatf("vec%0d_idle", i), 64'(busy), 64'd0);
    end
    check("table_perr", 64'(protocol_err), 64'd0);

    // Fill stalled by ready_ld low for 10 cycles.
    @(negedge clk);
    mif.addr_out_m     = 32'h0000_0400;
    mif.rw_out         = 1'b0;
    mif.addr_valid_out = 1'b1;
    wait_for(1'b1, lat);
    check("stall_latency", 64'(lat), 64'(LDL));
    held     = mif.data_in_m;
    unstable = 0;
    mif.addr_valid_out = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mif.valid_ld !== 1'b1 || mif.data_in_m !== held) unstable = 1;
    end
    check("stall_stable", 64'(unstable), 64'd0);
    check("stall_no_count", 64'(ld_count), 64'(exp_ld));
    push_expected(line_of(32'h0000_0400));
    check_line("stall_line", held);
    mif.ready_ld = 1'b1;
    @(posedge clk); #1;
    mif.ready_ld = 1'b0;
    exp_ld++;
    repeat (3) @(posedge clk); #1;
    check("stall_ld_count", 64'(ld_count), 64'(exp_ld));

    // Stray valid_wb in IDLE sets a sticky error.
    @(posedge clk); #1;
    mif.valid_wb = 1'b1;
    @(posedge clk); #1;
    mif.valid_wb = 1'b0;
    check("perr_wb_set", 64'(protocol_err), 64'd1);
    repeat (5) @(posedge clk); #1;
    check("perr_wb_sticky", 64'(protocol_err), 64'd1);
    apply_reset();
    #1;
    check("perr_wb_cleared", 64'(protocol_err), 64'd0);

    // Address changing while a load waits.
    @(negedge clk);
    mif.addr_out_m     = 32'h0000_0800;
    mif.rw_out         = 1'b0;
    mif.addr_valid_out = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("perr_addr_before", 64'(protocol_err), 64'd0);
    mif.addr_out_m = 32'h0000_0840;
    @(posedge clk); #1;
    check("perr_addr_set", 64'(protocol_err), 64'd1);
    mif.addr_out_m = 32'h0000_0800;
    lat = 0;
    while (!mif.valid_ld && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("perr_addr_fill_seen", 64'(mif.valid_ld), 64'd1);
    push_expected(line_of(32'h0000_0800));
    check_line("perr_addr_line", mif.data_in_m);
    mif.addr_valid_out = 1'b0;
    mif.ready_ld       = 1'b1;
    @(posedge clk); #1;
    mif.ready_ld = 1'b0;
    apply_reset();

    // Reset in the middle of a load after a writeback.
    do_wb("rst_mid", 32'h0000_0140, 32'hCAFE_F00D);
    @(negedge clk);
    mif.addr_out_m     = 32'h0000_0140;
    mif.rw_out         = 1'b0;
    mif.addr_valid_out = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_state", 64'(dbg_state), 64'(LD_WAIT));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid_ld", 64'(mif.valid_ld), 64'd0);
    check("rst_mid_wb_count", 64'(wb_count), 64'd0);
    mif.addr_valid_out = 1'b0;
    for (int i = 0; i < 256; i++) mdl_wr[i] = 0;
    exp_ld = 0;
    exp_wb = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load("post_rst", 32'h0000_0140, got);
    check("post_rst_word0", 64'(got[0 +: DW]), 64'h0000_0000_A5A0_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
